pixel_streamer: RTL
===================

# pixel_streamer

Frame source for the CNN datapath: on `start`, it reads a IMG_WIDTH×IMG_HEIGHT image, row-major, from a synchronous-read pixel memory (ROM/BRAM). It drives the pixels out on the `data_valid`/`data_out` stream consumed by the pixel Data_Buffer. Pixel rate is paced by a programmable idle gap and a downstream `stall`. `row_end` and `frame_end` markers accompany the stream.

## Interface
- DATA_SIZE, 8, pixel width in bits
- IMG_WIDTH, 28, pixels per row
- IMG_HEIGHT, 28, rows per frame
- ADDR_WIDTH, 10, memory address width; must satisfy 2^ADDR_WIDTH ≥ IMG_WIDTH×IMG_HEIGHT
- GAP_WIDTH, 4, width of the `gap` input
- clock  in  1  single clock; all logic is rising-edge
- resetn  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to stream one frame; ignored while `busy`
- gap  in  GAP_WIDTH  idle cycles inserted between pixels; sampled on accepted `start`
- stall  in  1  downstream hold; while high, no pixel is emitted and none is lost
- mem_en  out  1  memory read enable
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_rdata  in  DATA_SIZE  memory data; valid one cycle after an enabled read; held while `mem_en` is low
- data_valid  out  1  `data_out` holds a new pixel this cycle
- data_out  out  DATA_SIZE  pixel value
- row_end  out  1  high with the last pixel of each row
- frame_end  out  1  high with the last pixel of the frame
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last pixel

## Operation
- States: IDLE, RUN, FLUSH.
- **IDLE**:
  - `start` high at an edge → RUN.
  - On that edge: load col=0, row=0, address 0, and latch `gap` into gap_reg.
- **Advance condition**: `adv = ~stall & (gap_cnt == 0)`.
  - On an edge where `adv` is high, the three-stage pipeline moves one step: issue (mem_en, mem_addr) → read (pending flag) → output register.
  - On an edge where `adv` is low, every stage holds, `mem_en` is 0 and `data_valid` is 0. `data_out` keeps its last value.
- **gap_cnt**:
  - Reloads to gap_reg on each advancing edge.
  - Otherwise decrements only while `stall` is low.
  - gap=0 gives back-to-back pixels.
- **RUN**:
  - Issues addresses 0..N−1, where N = IMG_WIDTH×IMG_HEIGHT.
  - col wraps at IMG_WIDTH−1 and increments row; address increments linearly.
  - After issuing N−1 → FLUSH.
- **FLUSH**: no new issue; advances until the last pixel leaves the output register, then → IDLE and pulses `done`.
- **Markers**: `row_end` and `frame_end` travel down the pipeline alongside their pixel. They are only ever high together with `data_valid`.
- `start` while `busy` is ignored; `gap` changes mid-frame have no effect.
- `resetn` low at any edge, including mid-frame:
  - State goes to IDLE and the pipeline is emptied.
  - All outputs are 0 from the next cycle, with no `done` pulse.

## Timing
- Reset values: `mem_en`, `mem_addr`, `data_valid`, `data_out`, `row_end`, `frame_end`, `busy` and `done` are all 0.
- With `start` sampled at edge 0, gap=g and no stall:
  - pixel i is valid after edge 2+i·(g+1);
  - `done` is high for the one cycle after the edge following the last pixel;
  - `busy` is high from after edge 0 until `done` rises, and is low during the `done` cycle.
- A `start` in the `done` cycle is accepted.
- Each stall cycle delays all remaining pixels by exactly one cycle when g=0.
- When g>0, stall cycles also freeze the gap countdown.

## Structure
- Shared package `stream_pkg`:
  - state encoding (IDLE/RUN/FLUSH);
  - the frame-size function N = IMG_WIDTH×IMG_HEIGHT;
  - the default DATA_SIZE.
- Sub-module `frame_addr_counter`: row/col/linear-address counter with wrap, last-of-row and last-of-frame flags, and enable and clear inputs.
- The top level holds the FSM, gap counter and pipeline registers.

## Test plan
All tests use IMG_WIDTH=4, IMG_HEIGHT=3, with the memory model returning mem[a] = a+1.
- **Back-to-back**: gap=0, start → 12 consecutive valid pixels 1..12 starting 2 cycles after start. `row_end` on 4, 8 and 12; `frame_end` on 12; `done` one cycle later.
- **Gap of one**: gap=1 → `data_valid` alternates 1,0 with values 1..12. Frame spans 23 cycles; no gaps after pixel 12.
- **Mid-frame stall**: gap=0, `stall` high for 3 cycles after pixel 5 → `data_valid` low for exactly 3 cycles. Pixels 6..12 follow with no loss or duplication; `done` is delayed by 3 cycles.
- **Start while busy**: `start` pulsed again during pixel 7 → ignored; exactly 12 pixels and one `done`.
- **Reset mid-frame**: `resetn` low at pixel 6 → all outputs 0 next cycle, no `done`. A subsequent start streams 1..12 again from address 0.
- **Restart on done**: `start` during the `done` cycle → second frame begins correctly, and `gap` is re-sampled.

Source files
------------

// File: rtl/stream_pkg.sv
// stream_pkg: shared types and helpers for the pixel streamer.
// State encoding, frame size and default pixel width.
package stream_pkg;

  localparam int DATA_SIZE_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  function automatic int unsigned frame_size(
    input int unsigned w,
    input int unsigned h
  );
    return w * h;
  endfunction

endpackage

// File: rtl/pixel_streamer_if.sv
// pixel_streamer_if: control, memory-read and pixel-stream bundle.
// master = the streamer, slave = memory plus downstream consumer.
interface pixel_streamer_if
  import stream_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int ADDR_WIDTH = 10,
  parameter int GAP_WIDTH  = 4
);
  logic                  start;
  logic [GAP_WIDTH-1:0]  gap;
  logic                  stall;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_SIZE-1:0]  mem_rdata;
  logic                  data_valid;
  logic [DATA_SIZE-1:0]  data_out;
  logic                  row_end;
  logic                  frame_end;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, gap, stall, mem_rdata,
    output mem_en, mem_addr, data_valid, data_out,
    output row_end, frame_end, busy, done
  );

  modport slave (
    output start, gap, stall, mem_rdata,
    input  mem_en, mem_addr, data_valid, data_out,
    input  row_end, frame_end, busy, done
  );
endinterface

// File: rtl/frame_addr_counter.sv
// frame_addr_counter: row-major col/row/linear address walker.
// Flags describe the position currently held; wraps to 0 after the frame.
module frame_addr_counter #(
  parameter int W  = 28,
  parameter int H  = 28,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [AW-1:0] addr_o,
  output logic          last_col_o,
  output logic          last_frame_o
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          last_row;

  assign last_col_o   = (col_q == CW'(W - 1));
  assign last_row     = (row_q == RW'(H - 1));
  assign last_frame_o = last_col_o & last_row;
  assign addr_o       = addr_q;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clr_i || (en_i && last_frame_o)) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (en_i) begin
      addr_d = addr_q + 1'b1;
      if (last_col_o) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: rtl/pixel_streamer.sv
// pixel_streamer: reads one frame from a sync-read memory and streams it
// out with row/frame markers, paced by a programmable gap and a stall.
module pixel_streamer
  import stream_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int ADDR_WIDTH = 10,
  parameter int GAP_WIDTH  = 4
) (
  input logic              clock,
  input logic              resetn,
  pixel_streamer_if.master bus
);
  state_e                state_q, state_d;
  logic [GAP_WIDTH-1:0]  gap_reg_q, gap_cnt_q;
  logic                  pend_q, pend_row_q, pend_frm_q;
  logic                  dv_q, row_q, frm_q;
  logic                  done_q, done_d;
  logic [DATA_SIZE-1:0]  dout_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last_col, last_frame;
  logic                  adv, issue, take, start_ok;

  assign adv      = ~bus.stall & (gap_cnt_q == '0);
  assign issue    = (state_q == S_RUN) & adv;
  // read data waits in the pending slot until the output is free of stall
  assign take     = pend_q & ~bus.stall;
  assign start_ok = (state_q == S_IDLE) & bus.start;

  frame_addr_counter #(
    .W  (IMG_WIDTH),
    .H  (IMG_HEIGHT),
    .AW (ADDR_WIDTH)
  ) u_cnt (
    .clk_i        (clock),
    .rst_ni       (resetn),
    .clr_i        (start_ok),
    .en_i         (issue),
    .addr_o       (addr),
    .last_col_o   (last_col),
    .last_frame_o (last_frame)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (issue && last_frame) state_d = S_FLUSH;
      S_FLUSH: if (!pend_q) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      gap_reg_q  <= '0;
      gap_cnt_q  <= '0;
      pend_q     <= 1'b0;
      pend_row_q <= 1'b0;
      pend_frm_q <= 1'b0;
      dv_q       <= 1'b0;
      row_q      <= 1'b0;
      frm_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_ok) begin
        gap_reg_q <= bus.gap;
        gap_cnt_q <= '0;
      end else if (state_q != S_IDLE) begin
        if (adv) gap_cnt_q <= gap_reg_q;
        else if (!bus.stall) gap_cnt_q <= gap_cnt_q - 1'b1;
      end
      if (issue) begin
        pend_q     <= 1'b1;
        pend_row_q <= last_col;
        pend_frm_q <= last_frame;
      end else if (take) begin
        pend_q <= 1'b0;
      end
      dv_q  <= take;
      row_q <= take & pend_row_q;
      frm_q <= take & pend_frm_q;
      if (take) dout_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_en     = issue;
  assign bus.mem_addr   = addr;
  assign bus.data_valid = dv_q;
  assign bus.data_out   = dout_q;
  assign bus.row_end    = row_q;
  assign bus.frame_end  = frm_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
endmodule
